// File: rtl/rf_pkg.sv
// Shared widths and types for the 8x16 datapath register file.
package rf_pkg;

   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 3;
   localparam int NREGS     = 2 ** RF_ADDR_W;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_word_t;

endpackage

// File: rtl/rf_write_decoder.sv
// Turns the destination address and write enable into a one-hot per-register write strobe.
module rf_write_decoder
   import rf_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int N      = 2 ** ADDR_W
) (
   input  logic [ADDR_W-1:0] i_da,
   input  logic              i_rw,
   output logic [N-1:0]      o_we_onehot
);

   // Only a definite 1 writes; an unknown enable falls to the else path and holds state.
   always_comb begin
      o_we_onehot = '0;
      if (i_rw == 1'b1) begin
         o_we_onehot[i_da] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_file_8x16.sv
// 8 x 16-bit register file: two combinational read ports, one clocked write port.
// Optional write-through bypass on the read ports when REGFILE_BYPASS_EN is defined.
module reg_file_8x16
   import rf_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] AA,
   input  logic [ADDR_W-1:0] BA,
   input  logic [ADDR_W-1:0] DA,
   input  logic [DATA_W-1:0] busD,
   input  logic              RW,
   output logic [DATA_W-1:0] busA,
   output logic [DATA_W-1:0] busB
);

   localparam int N = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [N];
   logic [N-1:0]      w_we;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;

   rf_write_decoder #(
      .ADDR_W (ADDR_W),
      .N      (N)
   ) u_wdec (
      .i_da        (DA),
      .i_rw        (RW),
      .o_we_onehot (w_we)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < N; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_we[i]) begin
               r_regs[i] <= busD;
            end
         end
      end
   end

   assign w_rd_a = r_regs[AA];
   assign w_rd_b = r_regs[BA];

`ifdef REGFILE_BYPASS_EN
   // Forward the pending write data so a same-cycle read sees the new value.
   assign busA = (!RESET && RW && (DA == AA)) ? busD : w_rd_a;
   assign busB = (!RESET && RW && (DA == BA)) ? busD : w_rd_b;
`else
   assign busA = w_rd_a;
   assign busB = w_rd_b;
`endif

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed bench for reg_file_8x16 with a queue-based scoreboard and a decoupled monitor.
module tb_reg_file_8x16;

   localparam int W = 16;

   logic         CLK;
   logic         RESET;
   logic [2:0]   AA;
   logic [2:0]   BA;
   logic [2:0]   DA;
   logic [W-1:0] busD;
   logic         RW;
   logic [W-1:0] busA;
   logic [W-1:0] busB;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   logic         sample_tgl;
   int           total;
   int           bad;

   reg_file_8x16 dut (
      .CLK   (CLK),
      .RESET (RESET),
      .AA    (AA),
      .BA    (BA),
      .DA    (DA),
      .busD  (busD),
      .RW    (RW),
      .busA  (busA),
      .busB  (busB)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "bench timeout");
   end

   // driver tasks
   task automatic check(input string nm, input logic [2:0] aa, input logic [2:0] ba,
                        input logic [W-1:0] ea, input logic [W-1:0] eb);
      AA = aa;
      BA = ba;
      exp_q.push_back(ea);
      exp_q.push_back(eb);
      name_q.push_back(nm);
      sample_tgl = ~sample_tgl;
      #2;
   endtask

   task automatic write_reg(input logic [2:0] da, input logic [W-1:0] d);
      @(negedge CLK);
      DA   = da;
      busD = d;
      RW   = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RW   = 1'b0;
   endtask

   // scoreboard monitor: samples the buses 1 ns after each stimulus strobe
   initial begin
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      string nm;
      forever begin
         @(sample_tgl);
         #1;
         if (exp_q.size() < 2 || name_q.size() < 1) begin
            total++;
            bad++;
            $display("FAIL scoreboard_underflow actual=empty required=entry");
         end else begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (busA !== ea) begin
               bad++;
               $display("FAIL %s busA actual=%h required=%h", nm, busA, ea);
            end
            total++;
            if (busB !== eb) begin
               bad++;
               $display("FAIL %s busB actual=%h required=%h", nm, busB, eb);
            end
         end
      end
   end

   // stimulus
   initial begin
      total      = 0;
      bad        = 0;
      sample_tgl = 1'b0;
      RESET      = 1'b1;
      AA         = '0;
      BA         = '0;
      DA         = '0;
      busD       = '0;
      RW         = 1'b0;

      repeat (2) @(posedge CLK);
      for (int i = 0; i < 8; i++) begin
         check("reset_state", 3'(i), 3'(7 - i), 16'h0000, 16'h0000);
      end

      @(negedge CLK);
      RESET = 1'b0;

      for (int i = 0; i < 8; i++) begin
         write_reg(3'(i), 16'(16'h1111 * i));
      end
      for (int i = 0; i < 8; i++) begin
         check("read_all", 3'(i), 3'(7 - i), 16'(16'h1111 * i), 16'(16'h1111 * (7 - i)));
      end

      // write disabled
      @(negedge CLK);
      DA   = 3'd3;
      busD = 16'hDEAD;
      RW   = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("write_disable", 3'd3, 3'd4, 16'h3333, 16'h4444);

      // same-cycle read and write of R5
      @(negedge CLK);
      DA   = 3'd5;
      busD = 16'hBEEF;
      RW   = 1'b1;
`ifdef REGFILE_BYPASS_EN
      check("rw_same_before", 3'd5, 3'd5, 16'hBEEF, 16'hBEEF);
`else
      check("rw_same_before", 3'd5, 3'd5, 16'h5555, 16'h5555);
`endif
      @(posedge CLK);
      @(negedge CLK);
      RW = 1'b0;
      check("rw_same_after", 3'd5, 3'd5, 16'hBEEF, 16'hBEEF);

      // R0 is an ordinary register
      write_reg(3'd0, 16'hFFFF);
      check("r0_writable", 3'd0, 3'd1, 16'hFFFF, 16'h1111);

      // asynchronous reset mid-cycle, with a write pending across an edge
      @(posedge CLK);
      #2;
      RESET = 1'b1;
      DA    = 3'd2;
      busD  = 16'hA5A5;
      RW    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("async_reset", 3'(i), 3'(7 - i), 16'h0000, 16'h0000);
      end
      @(posedge CLK);
      @(negedge CLK);
      check("reset_blocks_write", 3'd2, 3'd2, 16'h0000, 16'h0000);
      RESET = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RW = 1'b0;
      check("write_after_release", 3'd2, 3'd3, 16'hA5A5, 16'h0000);

      // drain the scoreboard with a bounded wait
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
         #1;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
